// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and sequencer-state types for the ALU sequencer slice.
// Also holds the opcode-issue rules used when a request is accepted.
package alu_sequencer_pkg;

    typedef enum logic [4:0] {
        FnMem = 5'd0,
        FnADD = 5'd1,
        FnSUB = 5'd2,
        FnAND = 5'd3,
        FnOR  = 5'd4,
        FnNOT = 5'd5,
        FnLSL = 5'd6,
        FnLSR = 5'd7,
        FnNOP = 5'd31
    } fn_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Bit positions inside the {N,C,V,Z} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    function automatic logic is_shift(input fn_e op);
        return (op == FnLSL) || (op == FnLSR);
    endfunction

    // Opcode actually presented to the ALU for a freshly accepted request
    function automatic fn_e issue_op(input fn_e op, input logic shamt_zero);
        fn_e res;
        case (op)
            FnMem, FnADD, FnSUB, FnAND, FnOR, FnNOT, FnNOP: res = op;
            FnLSL, FnLSR: res = shamt_zero ? FnMem : op;
            default: res = FnNOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU driven by alu_sequencer; shifts move one bit per pass.
// Flags are {N,C,V,Z}; SUB sets C on no-borrow.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  fn_e              OpCode,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    always_comb begin
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (OpCode)
            FnMem: res = Op1;
            FnADD: begin
                sum   = {1'b0, Op1} + {1'b0, Op2};
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (Op1[WIDTH-1] == Op2[WIDTH-1]) && (res[WIDTH-1] != Op1[WIDTH-1]);
            end
            FnSUB: begin
                sum   = {1'b0, Op1} - {1'b0, Op2};
                res   = sum[WIDTH-1:0];
                carry = ~sum[WIDTH];
                ovf   = (Op1[WIDTH-1] != Op2[WIDTH-1]) && (res[WIDTH-1] != Op1[WIDTH-1]);
            end
            FnAND: res = Op1 & Op2;
            FnOR:  res = Op1 | Op2;
            FnNOT: res = ~Op1;
            FnLSL: begin
                res   = {Op1[WIDTH-2:0], 1'b0};
                carry = Op1[WIDTH-1];
            end
            FnLSR: begin
                res   = {1'b0, Op1[WIDTH-1:1]};
                carry = Op1[0];
            end
            default: res = '0;
        endcase
    end

    assign Result = res;

    always_comb begin
        Flags         = '0;
        Flags[FLAG_N] = res[WIDTH-1];
        Flags[FLAG_C] = carry;
        Flags[FLAG_V] = ovf;
        Flags[FLAG_Z] = (res == '0);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer that drives an external ALU: single-pass ops
// take one EXEC cycle, shifts iterate one bit per SHIFT cycle.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  fn_e              ReqOp,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    input  logic [SHW-1:0]   ReqShamt,
    output logic [WIDTH-1:0] AluOp1,
    output logic [WIDTH-1:0] AluOp2,
    output fn_e              AluOpCode,
    input  logic [WIDTH-1:0] AluResult,
    input  logic [3:0]       AluFlags,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspResult,
    output logic [3:0]       RspFlags,
    output logic             Busy
);

    seq_state_e       state_reg, state_next;
    fn_e              op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] w_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;

    logic             accept;
    logic             shamt_zero;
    logic             shift_last;
    logic             capture;
    logic [3:0]       flags_next;
    logic             alu_z_unused;

    assign accept     = (state_reg == IDLE) && ReqValid;
    assign shamt_zero = (ReqShamt == '0);
    assign shift_last = (cnt_reg == SHW'(1));
    assign capture    = (state_reg == EXEC) || ((state_reg == SHIFT) && shift_last);

    // Z is rebuilt from the result rather than trusted from the ALU
    assign alu_z_unused = AluFlags[FLAG_Z];
    always_comb begin
        flags_next         = AluFlags;
        flags_next[FLAG_Z] = (AluResult == '0);
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ReqValid) begin
                    state_next = (is_shift(ReqOp) && !shamt_zero) ? SHIFT : EXEC;
                end
            end
            EXEC:  state_next = DONE;
            SHIFT: begin
                if (shift_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (RspReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ReqReady  = (state_reg == IDLE);
        Busy      = (state_reg != IDLE);
        RspValid  = (state_reg == DONE);
        AluOp1    = '0;
        AluOp2    = '0;
        AluOpCode = FnNOP;
        case (state_reg)
            EXEC: begin
                AluOp1    = a_reg;
                AluOp2    = b_reg;
                AluOpCode = op_reg;
            end
            SHIFT: begin
                AluOp1    = w_reg;
                AluOpCode = op_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            op_reg     <= FnNOP;
            a_reg      <= '0;
            b_reg      <= '0;
            w_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            if (accept) begin
                op_reg  <= issue_op(ReqOp, shamt_zero);
                a_reg   <= ReqA;
                b_reg   <= ReqB;
                w_reg   <= ReqA;
                cnt_reg <= ReqShamt;
            end
            if (state_reg == SHIFT) begin
                w_reg   <= AluResult;
                cnt_reg <= cnt_reg - SHW'(1);
            end
            if (capture) begin
                result_reg <= AluResult;
                flags_reg  <= flags_next;
            end
        end
    end

    assign RspResult = result_reg;
    assign RspFlags  = flags_reg;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width; all data ports below are WIDTH bits.
REQ-002 Parameter SHW, default 4: shift-count width; the maximum shift is 2**SHW-1.
REQ-003 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 nReset  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-005 ReqValid  input  1  request present.
REQ-006 ReqReady  output  1  sequencer can accept a request.
REQ-007 ReqOp  input  5  function code, type from the shared opcodes package (FnMem, FnADD, FnSUB, FnAND, FnOR, FnNOT, FnLSL, FnLSR, FnNOP).
REQ-008 ReqA, ReqB  input  WIDTH  operands.
REQ-009 ReqShamt  input  SHW  shift count; used only for FnLSL and FnLSR.
REQ-010 AluOp1, AluOp2  output  WIDTH  operands driven to the ALU.
REQ-011 AluOpCode  output  5  function driven to the ALU.
REQ-012 AluResult  input  WIDTH  ALU result, combinational from the Alu* outputs.
REQ-013 AluFlags  input  4  ALU flags {N,C,V,Z}, combinational.
REQ-014 RspValid  output  1  response present.
REQ-015 RspReady  input  1  consumer accepts the response.
REQ-016 RspResult  output  WIDTH  final result.
REQ-017 RspFlags  output  4  final flags {N,C,V,Z}.
REQ-018 Busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, EXEC, SHIFT, DONE.
REQ-020 ReqReady shall be 1 only in IDLE; a request is accepted when ReqValid&&ReqReady at a rising edge.
REQ-021 On accept, the sequencer latches op, A, B and shamt. It then goes to SHIFT for FnLSL/FnLSR with shamt>0, otherwise to EXEC.
REQ-022 EXEC drives AluOp1=A, AluOp2=B and AluOpCode=op, captures AluResult/AluFlags, then goes to DONE (one cycle).
REQ-023 An undefined opcode is issued to the ALU as FnNOP.
REQ-024 FnLSL/FnLSR with shamt=0 is issued as FnMem in EXEC (result=A).
REQ-025 SHIFT holds a working register W (initialised to A) and a down-counter (initialised to shamt).
REQ-026 Each SHIFT cycle drives AluOp1=W and AluOpCode=op, loads W<=AluResult and decrements the counter.
REQ-027 SHIFT exits to DONE on the cycle the counter reaches 0, capturing that cycle's AluResult/AluFlags.
REQ-028 Latency from accept to RspValid: 2 cycles for single-pass ops; shamt+1 cycles for shifts.
REQ-029 RspFlags Z bit shall be recomputed locally as (RspResult==0); N, C and V are taken from AluFlags of the final ALU cycle.
REQ-030 DONE asserts RspValid with stable RspResult/RspFlags until RspReady; on RspValid&&RspReady the FSM returns to IDLE.
REQ-031 ReqReady stays 0 in the DONE→IDLE cycle; back-to-back throughput is one op per (latency+1) cycles at minimum.
REQ-032 Outside EXEC/SHIFT, AluOpCode=FnNOP and AluOp1/AluOp2=0.
REQ-033 RspResult/RspFlags hold their last values while not in DONE.

Reset
REQ-034 When nReset=0 at a rising edge, the sequencer shall enter IDLE, whatever the current state.
REQ-035 Reset values: ReqReady=1 (following the release of reset), RspValid=0, Busy=0, RspResult=0, RspFlags=0, W=0, counter=0.
REQ-036 Reset mid-EXEC, mid-SHIFT or in DONE shall discard the operation with no response.

Structure
REQ-037 The FSM state enum and the Fn* opcode type shall come from the shared opcodes package; no local opcode literals.
REQ-038 The ALU is not instantiated inside alu_sequencer; the parent connects it. For unit test, a wrapper alu_sequencer_tb_top instantiates alu_sequencer plus alu.

Verification
REQ-039 FnADD A=16'h0003, B=16'h0004 → RspValid 2 cycles after accept, RspResult=16'h0007, Z=0.
REQ-040 FnSUB A=B=16'h1234 → RspResult=0, RspFlags Z=1.
REQ-041 FnLSL A=16'h0001, shamt=15 → exactly 15 SHIFT cycles, RspResult=16'h8000, RspValid at cycle 16 after accept.
REQ-042 FnLSR A=16'hF0F0, shamt=0 → single EXEC with AluOpCode=FnMem, RspResult=16'hF0F0.
REQ-043 RspReady held low for 5 cycles in DONE → RspValid and RspResult stable, ReqReady=0 throughout, ReqValid ignored.
REQ-044 nReset pulsed low during SHIFT of a shamt=8 op → next cycle IDLE, RspValid never asserted, next request completes normally.
